ofmap_writeback: RTL
====================

Name: ofmap_writeback

Overview:
- Downstream of the weight-stationary PE array top.
- Consumes the per-pixel `valid`/`acc` stream (21-bit signed partial sums, one per output pixel) and applies bias, optional ReLU, rounding right-shift and int8 saturation.
- Packs 4 results per 32-bit word and writes them to the output feature-map SRAM through a ready/enable write port.
- Has a 2-entry skid FIFO, because the array has no backpressure input.

Parameters:
- ACC_W, 21, width of incoming accumulator.
- OUT_W, 8, width of each quantized output pixel.
- PACK, 4, pixels per SRAM word (word width = PACK*OUT_W = 32).
- SHIFT, 4, requantization right-shift amount, ≥1.
- FRAME_PIX, 36, output pixels per frame; a multiple of PACK is not required.
- ADDR_W, 6, output SRAM address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  acc_i carries a finished pixel this cycle.
- acc_i  in  ACC_W  signed accumulator value.
- bias_i  in  ACC_W  signed bias; static during a frame.
- relu_en_i  in  1  1 = clamp negatives to 0 before the shift.
- wr_en_o  out  1  SRAM write request.
- wr_addr_o  out  ADDR_W  SRAM word address.
- wr_data_o  out  32  packed word; pixel k occupies bits [8k+7:8k].
- wr_ready_i  in  1  SRAM accepts the write this cycle.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse, frame fully written.
- ovf_o  out  1  sticky, a word was dropped.

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, ovf_o all 0.
  - FIFO empty, lane index 0, pixel count 0, pipeline valids 0.
  - Reset mid-frame discards the partial word and FIFO contents.
- Stage 1, registered in the cycle after valid_i:
  - s = acc_i + bias_i, ACC_W+1 bits signed.
  - If relu_en_i and s<0, then s=0.
- Stage 2, registered:
  - r = (s + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift (round half up).
  - Saturate r to [-128, 127].
- Packer:
  - The stage-2 byte goes into lane[idx]; idx increments 0..PACK-1.
  - A word is pushed to the FIFO when lane PACK-1 fills, or when the frame's last pixel arrives; unfilled lanes are padded with 0.
  - idx resets to 0 after each push.
- Latency: the 4th pixel's valid_i at cycle t gives wr_en_o=1 at t+3 (FIFO was empty).
- FIFO, 2 entries:
  - Head drives wr_data_o/wr_addr_o; wr_en_o = FIFO non-empty.
  - Transfer occurs when wr_en_o && wr_ready_i.
  - wr_data_o and wr_addr_o are held stable while wr_en_o=1 and wr_ready_i=0.
  - Push and pop in the same cycle are always accepted, including when full.
  - Push when full without a pop: the word is dropped and ovf_o←1 until rst.
- Addressing:
  - wr_addr_o starts at 0 and increments on each transfer.
  - After the final word of the frame (ceil(FRAME_PIX/PACK)-1) is transferred, the address wraps to 0.
- Frame control:
  - busy_o←1 on the first valid_i of a frame.
  - done_o=1 for exactly one cycle, the cycle after the final word's transfer; busy_o←0 in that same cycle.
  - A new frame's valid_i may arrive while busy; the pixel count wraps at FRAME_PIX, and the next frame starts at lane 0.
- Pixels arriving back-to-back every cycle are sustained with no bubbles when wr_ready_i=1.

Test Plan:
- Quantize and pack, relu_en=1, bias=0: acc 100, 16, -50, 4095 on consecutive cycles -> single write, addr 0, data 0x7F000106, wr_en_o 3 cycles after the 4th valid.
- Negative rounding and saturation, relu_en=0, bias=0: acc -50, -1048576, 7, 0 -> data 0x000080FD (-42>>>4 = -3 = 0xFD; min saturates to 0x80; (7+8)>>4 = 0).
- Bias, relu_en=1: bias=-200, acc=100 ×4 -> data 0x00000000. Then bias=+40, acc=8 ×4 -> data 0x03030303.
- Full frame, wr_ready=1, 36 back-to-back valids:
  - 9 writes on addr 0..8.
  - done_o is a single pulse after the write to addr 8, and busy_o then drops.
  - The next frame starts at addr 0.
- Backpressure: hold wr_ready=0.
  - 8 pixels -> 2 words queued, ovf_o=0.
  - Then wr_ready=1 -> addr 0 and 1 written in order, data held stable throughout the stall.
  - Repeat with 12 pixels -> ovf_o=1 and stays 1; only 2 words are written.
- Reset mid-frame: assert rst for 1 cycle after 5 pixels -> all outputs 0 next cycle. A following 4-pixel group writes addr 0 with lane 0 = first new pixel.

Source files
------------

// File: rtl/ofmap_writeback.sv
// ofmap_writeback: bias, ReLU, round-shift and int8 saturation of PE-array
// partial sums, packed four per word into a 2-entry skid FIFO to the SRAM.
module ofmap_writeback #(
   parameter int ACC_W     = 21,
   parameter int OUT_W     = 8,
   parameter int PACK      = 4,
   parameter int SHIFT     = 4,
   parameter int FRAME_PIX = 36,
   parameter int ADDR_W    = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [ACC_W-1:0]      acc_i,
   input  logic [ACC_W-1:0]      bias_i,
   input  logic                  relu_en_i,
   output logic                  wr_en_o,
   output logic [ADDR_W-1:0]     wr_addr_o,
   output logic [PACK*OUT_W-1:0] wr_data_o,
   input  logic                  wr_ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ovf_o
);

   localparam int WORD_W = PACK * OUT_W;
   localparam int IDX_W  = $clog2(PACK);
   localparam int CNT_W  = $clog2(FRAME_PIX);
   localparam int RW     = ACC_W + 2;

   localparam logic [RW-1:0] RND = RW'(1) << (SHIFT - 1);
   localparam logic signed [RW-1:0] MAX_V =
      {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [RW-1:0] MIN_V =
      {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

   // stage 1: bias add and optional ReLU
   logic                    v1_q, v1_d;
   logic signed [ACC_W:0]   s1_q, s1_d;
   logic signed [ACC_W:0]   sum;

   // stage 2: rounding shift and saturation
   logic                    v2_q, v2_d;
   logic [OUT_W-1:0]        b2_q, b2_d;
   logic signed [RW-1:0]    rs;
   logic signed [RW-1:0]    r;

   // packer
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0]       lane_q, lane_d;
   logic [WORD_W-1:0]       word;
   logic                    last;
   logic                    push;
   logic [WORD_W-1:0]       push_data;
   logic                    push_last;

   // skid FIFO, entry = {last-of-frame, data}
   logic [WORD_W:0]         mem_q [2];
   logic [WORD_W:0]         mem_d [2];
   logic                    rp_q, rp_d;
   logic                    wp_q, wp_d;
   logic [1:0]              fc_q, fc_d;
   logic                    pop;
   logic                    full;
   logic                    accept;
   logic                    drop;
   logic                    head_last;

   // frame control and addressing
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    ovf_q, ovf_d;

   // stage 1 next state: sign-extended add, negatives clamped under ReLU
   always_comb begin
      sum  = $signed({acc_i[ACC_W-1], acc_i}) +
             $signed({bias_i[ACC_W-1], bias_i});
      s1_d = (relu_en_i && sum[ACC_W]) ? '0 : sum;
      v1_d = valid_i;
   end

   // stage 2 next state: round half up, arithmetic shift, clamp to int8
   always_comb begin
      rs = $signed({s1_q[ACC_W], s1_q}) + $signed(RND);
      r  = rs >>> SHIFT;
      if (r > MAX_V) begin
         b2_d = MAX_V[OUT_W-1:0];
      end else if (r < MIN_V) begin
         b2_d = MIN_V[OUT_W-1:0];
      end else begin
         b2_d = r[OUT_W-1:0];
      end
      v2_d = v1_q;
   end

   // packer: fill lanes, emit a word on a full lane set or frame end
   always_comb begin
      lane_d    = lane_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      word      = lane_q;
      last      = 1'b0;
      push      = 1'b0;
      push_data = lane_q;
      push_last = 1'b0;
      if (v2_q) begin
         word[idx_q*OUT_W +: OUT_W] = b2_q;
         last  = (cnt_q == CNT_W'(FRAME_PIX - 1));
         cnt_d = last ? '0 : cnt_q + 1'b1;
         if (idx_q == IDX_W'(PACK - 1) || last) begin
            push      = 1'b1;
            push_data = word;
            push_last = last;
            lane_d    = '0;
            idx_d     = '0;
         end else begin
            lane_d = word;
            idx_d  = idx_q + 1'b1;
         end
      end
   end

   // FIFO bookkeeping: simultaneous push and pop always succeed
   always_comb begin
      pop       = (fc_q != 2'd0) && wr_ready_i;
      full      = (fc_q == 2'd2);
      accept    = push && (!full || pop);
      drop      = push && full && !pop;
      head_last = mem_q[rp_q][WORD_W];
      mem_d     = mem_q;
      if (accept) begin
         mem_d[wp_q] = {push_last, push_data};
      end
      wp_d = wp_q ^ accept;
      rp_d = rp_q ^ pop;
      fc_d = fc_q + {1'b0, accept} - {1'b0, pop};
   end

   // address, done pulse, busy and sticky overflow
   always_comb begin
      addr_d = addr_q;
      if (pop) begin
         addr_d = head_last ? '0 : addr_q + 1'b1;
      end
      done_d = pop && head_last;
      busy_d = busy_q;
      if (done_d) begin
         busy_d = 1'b0;
      end
      if (valid_i) begin
         busy_d = 1'b1;
      end
      ovf_d = ovf_q | drop;
   end

   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q     <= 1'b0;
         s1_q     <= '0;
         v2_q     <= 1'b0;
         b2_q     <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         lane_q   <= '0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rp_q     <= 1'b0;
         wp_q     <= 1'b0;
         fc_q     <= 2'd0;
         addr_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         v1_q     <= v1_d;
         s1_q     <= s1_d;
         v2_q     <= v2_d;
         b2_q     <= b2_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         lane_q   <= lane_d;
         mem_q    <= mem_d;
         rp_q     <= rp_d;
         wp_q     <= wp_d;
         fc_q     <= fc_d;
         addr_q   <= addr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   assign wr_en_o   = (fc_q != 2'd0);
   assign wr_addr_o = addr_q;
   assign wr_data_o = mem_q[rp_q][WORD_W-1:0];
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign ovf_o     = ovf_q;

endmodule
